// File: rtl/interrupt_controller_n.sv
// NUM_SRC-source maskable interrupt controller with level/edge modes, W1C pending and a registered priority ID.
// Optional software-set register at address 5 is built only when IRQ_SW_SET_EN is defined.
module interrupt_controller_n #(
    parameter int NUM_SRC       = 8,
    parameter int DATA_REG_BITS = 32,
    parameter int ID_BITS       = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               address,
    input  logic                     wr,
    input  logic [DATA_REG_BITS-1:0] wr_data,
    input  logic [NUM_SRC-1:0]       src,
    output logic [DATA_REG_BITS-1:0] rd_data,
    output logic [ID_BITS-1:0]       irq_id,
    output logic                     irq_id_valid,
    output logic                     irq
);

    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_mode;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_src_prev;
    logic [ID_BITS-1:0] r_irq_id;
    logic               r_irq_id_valid;

    logic [NUM_SRC-1:0] w_event;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic               w_unused_wr_data;

    // Scan downward so the lowest set index is the last one written.
    function automatic logic [ID_BITS-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        logic [ID_BITS-1:0] idx;
        idx = {ID_BITS{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_BITS'(i);
            end
        end
        return idx;
    endfunction

    assign w_event = (src & ~r_src_prev & r_mode) | (src & ~r_mode);
    assign w_clr   = (wr && (address == 3'd3)) ? wr_data[NUM_SRC-1:0] : {NUM_SRC{1'b0}};

`ifdef IRQ_SW_SET_EN
    logic [NUM_SRC-1:0] w_sw_set;
    assign w_sw_set = (wr && (address == 3'd5)) ? wr_data[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
    assign w_set    = w_event | w_sw_set;
`else
    assign w_set    = w_event;
`endif

    // Mask dominates, then set beats a simultaneous clear so no event is lost.
    assign w_pending_nxt    = r_mask & (w_set | (r_pending & ~w_clr));
    assign w_unused_wr_data = ^wr_data;

    // Control/status registers, edge history and the registered priority ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask         <= {NUM_SRC{1'b0}};
            r_mode         <= {NUM_SRC{1'b0}};
            r_pending      <= {NUM_SRC{1'b0}};
            r_src_prev     <= {NUM_SRC{1'b0}};
            r_irq_id       <= {ID_BITS{1'b0}};
            r_irq_id_valid <= 1'b0;
        end else begin
            r_src_prev     <= src;
            r_pending      <= w_pending_nxt;
            r_irq_id       <= lowest_idx(r_pending);
            r_irq_id_valid <= |r_pending;
            if (wr && (address == 3'd0)) begin
                r_mask <= wr_data[NUM_SRC-1:0];
            end
            if (wr && (address == 3'd1)) begin
                r_mode <= wr_data[NUM_SRC-1:0];
            end
        end
    end

    // Read mux; unmapped addresses and unused upper bits read zero.
    always_comb begin
        rd_data = {DATA_REG_BITS{1'b0}};
        case (address)
            3'd0: rd_data[NUM_SRC-1:0] = r_mask;
            3'd1: rd_data[NUM_SRC-1:0] = r_mode;
            3'd2: rd_data[NUM_SRC-1:0] = src;
            3'd3: rd_data[NUM_SRC-1:0] = r_pending;
            3'd4: begin
                rd_data[ID_BITS-1:0] = r_irq_id;
                rd_data[8]           = r_irq_id_valid;
            end
            default: rd_data = {DATA_REG_BITS{1'b0}};
        endcase
    end

    assign irq          = |r_pending;
    assign irq_id       = r_irq_id;
    assign irq_id_valid = r_irq_id_valid;

endmodule

// File: tb/tb_interrupt_controller_n.sv
// Scoreboard bench for interrupt_controller_n: expectations are queued after each stimulus step and drained against the DUT.
`timescale 1ns/1ps
module tb_interrupt_controller_n;

    logic        clk;
    logic        rst;
    logic [2:0]  address;
    logic        wr;
    logic [31:0] wr_data;
    logic [7:0]  src;
    logic [31:0] rd_data;
    logic [4:0]  irq_id;
    logic        irq_id_valid;
    logic        irq;

    int n_tests;
    int n_fail;

    // sel 0..7 = register read at that address, 8 = irq, 9 = irq_id, 10 = irq_id_valid
    typedef struct {
        string       tag;
        logic [3:0]  sel;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    interrupt_controller_n #(
        .NUM_SRC      (8),
        .DATA_REG_BITS(32),
        .ID_BITS      (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .wr          (wr),
        .wr_data     (wr_data),
        .src         (src),
        .rd_data     (rd_data),
        .irq_id      (irq_id),
        .irq_id_valid(irq_id_valid),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        address = a;
        wr_data = d;
        wr      = 1'b1;
        tick();
        wr      = 1'b0;
        wr_data = 32'd0;
    endtask

    task automatic expect_val(input string tag, input logic [3:0] sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t   e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.sel < 4'd8) begin
                address = e.sel[2:0];
                #1;
                obs = rd_data;
            end else if (e.sel == 4'd8) begin
                obs = {31'd0, irq};
            end else if (e.sel == 4'd9) begin
                obs = {27'd0, irq_id};
            end else begin
                obs = {31'd0, irq_id_valid};
            end
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        wr      = 1'b0;
        address = 3'd0;
        wr_data = 32'd0;
        src     = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        expect_val("rst_mask", 4'd0, 32'h0);
        expect_val("rst_mode", 4'd1, 32'h0);
        expect_val("rst_pend", 4'd3, 32'h0);
        expect_val("rst_id", 4'd4, 32'h0);
        expect_val("rst_irq", 4'd8, 32'h0);
        expect_val("rst_a6", 4'd6, 32'h0);
        drain();

        // Level source: W1C is ineffective while src stays high.
        wr_reg(3'd0, 32'h0000_00FF);
        src = 8'h04;
        tick();
        expect_val("lvl_pend", 4'd3, 32'h04);
        expect_val("lvl_irq", 4'd8, 32'h1);
        expect_val("lvl_raw", 4'd2, 32'h04);
        drain();
        tick();
        expect_val("lvl_id", 4'd4, 32'h102);
        drain();
        wr_reg(3'd3, 32'h04);
        expect_val("lvl_w1c_hi", 4'd3, 32'h04);
        drain();
        src = 8'h00;
        wr_reg(3'd3, 32'h04);
        expect_val("lvl_w1c_lo", 4'd3, 32'h00);
        expect_val("lvl_irq0", 4'd8, 32'h0);
        drain();
        tick();
        expect_val("lvl_id0", 4'd4, 32'h0);
        drain();

        // Edge source: one-cycle pulse latches pending, ID follows a cycle later.
        wr_reg(3'd1, 32'h01);
        wr_reg(3'd0, 32'h01);
        src = 8'h01;
        tick();
        src = 8'h00;
        expect_val("edg_pend", 4'd3, 32'h01);
        expect_val("edg_irq", 4'd8, 32'h1);
        expect_val("edg_vld_lag", 4'd10, 32'h0);
        drain();
        tick();
        expect_val("edg_hold", 4'd3, 32'h01);
        expect_val("edg_vld", 4'd10, 32'h1);
        expect_val("edg_id", 4'd9, 32'h0);
        drain();
        wr_reg(3'd3, 32'h01);
        expect_val("edg_clr_irq", 4'd8, 32'h0);
        drain();
        tick();
        expect_val("edg_clr_vld", 4'd10, 32'h0);
        drain();

        // Edge set beats a simultaneous W1C.
        wr_reg(3'd0, 32'h02);
        wr_reg(3'd1, 32'h02);
        src = 8'h02;
        tick();
        src = 8'h00;
        tick();
        src = 8'h02;
        wr_reg(3'd3, 32'h02);
        expect_val("race_pend", 4'd3, 32'h02);
        drain();
        wr_reg(3'd3, 32'h02);
        expect_val("race_clr", 4'd3, 32'h00);
        drain();
        src = 8'h00;

        // Priority ID walk over pending = 0x28.
        wr_reg(3'd0, 32'h28);
        wr_reg(3'd1, 32'h00);
        src = 8'h28;
        tick();
        src = 8'h00;
        tick();
        expect_val("pri_pend", 4'd3, 32'h28);
        expect_val("pri_id3", 4'd4, 32'h103);
        drain();
        wr_reg(3'd3, 32'h08);
        tick();
        expect_val("pri_id5", 4'd4, 32'h105);
        drain();
        wr_reg(3'd3, 32'h20);
        tick();
        expect_val("pri_id0", 4'd4, 32'h000);
        expect_val("pri_irq0", 4'd8, 32'h0);
        drain();

        // Masked edge source never shows up, and unmasking does not revive its edge.
        wr_reg(3'd0, 32'h01);
        wr_reg(3'd1, 32'h10);
        src = 8'h10;
        tick();
        src = 8'h00;
        tick();
        expect_val("msk_pend", 4'd3, 32'h00);
        drain();
        src = 8'h10;
        tick();
        wr_reg(3'd0, 32'h10);
        tick();
        tick();
        expect_val("unmsk_pend", 4'd3, 32'h00);
        drain();
        src = 8'h00;

        // Upper bits of mask do not exist; unmapped address reads zero.
        wr_reg(3'd1, 32'h00);
        wr_reg(3'd0, 32'hFFFF_FFFF);
        expect_val("msk_width", 4'd0, 32'hFF);
        expect_val("a7_zero", 4'd7, 32'h0);
        drain();

        // Reset in the middle of full activity.
        src = 8'hFF;
        tick();
        src = 8'h00;
        tick();
        expect_val("pre_rst_pend", 4'd3, 32'hFF);
        drain();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_val("mid_rst_mask", 4'd0, 32'h0);
        expect_val("mid_rst_pend", 4'd3, 32'h0);
        expect_val("mid_rst_id", 4'd4, 32'h0);
        expect_val("mid_rst_irq", 4'd8, 32'h0);
        drain();

        // Software set at address 5, gated by the mask.
        wr_reg(3'd0, 32'h80);
        wr_reg(3'd5, 32'h80);
`ifdef IRQ_SW_SET_EN
        expect_val("sw_pend", 4'd3, 32'h80);
        expect_val("sw_irq", 4'd8, 32'h1);
`else
        expect_val("sw_pend", 4'd3, 32'h00);
        expect_val("sw_irq", 4'd8, 32'h0);
`endif
        expect_val("sw_rd5", 4'd5, 32'h0);
        drain();
        wr_reg(3'd3, 32'h80);
        wr_reg(3'd0, 32'h00);
        wr_reg(3'd5, 32'h80);
        expect_val("sw_masked", 4'd3, 32'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
